wrr_packet_arbiter: RTL
=======================

// Module: wrr_packet_arbiter
// PURPOSE
//  Weighted round-robin arbiter sharing one beat-oriented channel among PORTS packet sources.
//  Grant is held for whole packets; port i may send up to weight[i] packets per turn.
//  Sits between requesters and a shared downstream resource (bus master, FIFO write port).
//  Clock 'clk'; reset 'rst' is synchronous, active-high.
// PARAMETERS
//  PORTS   8  number of requesting ports (>=2)
//  WWIDTH  4  bits per port weight field
// PORTS
//  clk         in   1             clock
//  rst         in   1             synchronous active-high reset
//  req         in   PORTS         per-port beat valid; held high until beat transferred
//  last        in   PORTS         per-port last beat of packet (qualified by req)
//  weight      in   PORTS*WWIDTH  packets per turn, port i at [i*WWIDTH +: WWIDTH]; 0 => 1
//  ready       in   1             downstream accepts a beat this cycle
//  grant       out  PORTS         one-hot registered grant
//  grant_port  out  $clog2(PORTS) index of granted port
//  grant_dv    out  1             grant/grant_port valid
//  port_ready  out  PORTS         grant & {PORTS{ready & grant_dv}} (combinational from ready)
//  xfer        out  1             |(port_ready & req): beat transferred this cycle
// BEHAVIOUR
//  Reset: grant=0, grant_port=0, grant_dv=0, state=IDLE, pkt_cnt=0, at_bound=1,
//   prio_ptr=one-hot bit0. Reset mid-packet abandons the packet; nothing is retained.
//  FSM states: IDLE, GRANT.
//  IDLE: if |req, pick winner = first req bit at or above prio_ptr, wrapping past MSB to LSB.
//   Next cycle: state=GRANT, grant=winner, grant_port=index, grant_dv=1,
//   wt_lat=weight[winner] (0 => 1), pkt_cnt=0, at_bound=1. Latency req->grant: 1 cycle.
//   If req==0, stay in IDLE; outputs stay 0.
//  GRANT, per cycle with g = grant_port:
//   - req[g] & ready: beat transferred, xfer=1, at_bound=0.
//   - Transfer with last[g]: at_bound=1. If pkt_cnt+1 < wt_lat: pkt_cnt++, stay in GRANT.
//     Else release.
//   - at_bound=1 & req[g]=0: release (no data for another packet).
//   - req[g]=1 & ready=0: hold. No counter change; grant is never revoked mid-packet.
//  Release: next cycle grant=0, grant_dv=0, grant_port unchanged, state=IDLE,
//   prio_ptr = grant rotated left by 1 (MSB wraps to bit0).
//   One IDLE bubble cycle always separates consecutive grants.
//  last on non-granted ports is ignored. weight changes take effect at the next grant only.
//  pkt_cnt width WWIDTH; never exceeds wt_lat-1.
//  Starvation-free: any requester is granted within PORTS turns.
// TESTING
//  1 rst=1 2 cycles with req=FF -> grant=00, grant_dv=0. Release rst, req=01 -> grant=01 at next cycle.
//  2 req=FF, all weights=1, single-beat packets (last=FF), ready=1 -> grants 01,02,04..80,01.
//    Each grant lasts 1 cycle with 1 IDLE cycle between grants.
//  3 weight[2]=3, only port 2 requesting, continuous 1-beat packets -> grant=04 for 3 xfers, then release.
//    Next IDLE re-grants 04 (prio_ptr=08, wraps).
//  4 weight[1]=4, port 1 drops req after first packet's last beat -> grant cleared next cycle.
//    Port 3 (req=08) is granted the cycle after.
//  5 port 0 granted, 4-beat packet, ready=0 for 5 cycles after beat 2 -> grant held, xfer=0.
//    Packet completes with 4 xfers total.
//  6 rst pulsed while grant=10 mid-packet -> next cycle grant=0, grant_dv=0.
//    With req=FF, next grant=01.

Source files
------------

// File: rtl/wrr_packet_arbiter_if.sv
// Handshake bundle between packet sources and the weighted round-robin arbiter.
interface wrr_packet_arbiter_if #(
    parameter int unsigned PORTS  = 8,
    parameter int unsigned WWIDTH = 4
);
    localparam int unsigned PW = $clog2(PORTS);

    logic [PORTS-1:0]        req;
    logic [PORTS-1:0]        last;
    logic [PORTS*WWIDTH-1:0] weight;
    logic                    ready;
    logic [PORTS-1:0]        grant;
    logic [PW-1:0]           grant_port;
    logic                    grant_dv;
    logic [PORTS-1:0]        port_ready;
    logic                    xfer;

    // Arbiter side
    modport slave (
        input  req, last, weight, ready,
        output grant, grant_port, grant_dv, port_ready, xfer
    );

    // Requester / downstream side
    modport master (
        output req, last, weight, ready,
        input  grant, grant_port, grant_dv, port_ready, xfer
    );
endinterface

// File: rtl/wrr_packet_arbiter.sv
// Weighted round-robin arbiter: grants whole packets, up to weight[i] packets per turn.
module wrr_packet_arbiter #(
    parameter int unsigned PORTS  = 8,
    parameter int unsigned WWIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    wrr_packet_arbiter_if.slave   bus
);
    localparam int unsigned PW = $clog2(PORTS);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [PORTS-1:0]    grant_q, grant_d;
    logic [PW-1:0]       grant_port_q, grant_port_d;
    logic                grant_dv_q, grant_dv_d;
    logic [WWIDTH-1:0]   wt_lat_q, wt_lat_d;
    logic [WWIDTH-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic                at_bound_q, at_bound_d;
    logic [PORTS-1:0]    prio_ptr_q, prio_ptr_d;

    logic [PW-1:0]       ptr_idx;
    logic [PW-1:0]       win_idx;
    logic [WWIDTH-1:0]   win_weight;
    logic [WWIDTH:0]     cnt_inc;
    logic                req_g;
    logic                last_g;
    logic [PORTS-1:0]    port_ready_c;

    // Index of the one-hot priority pointer
    always_comb begin
        ptr_idx = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (prio_ptr_q[i]) begin
                ptr_idx = PW'(i);
            end
        end
    end

    // First requester at or above the pointer, wrapping past the MSB
    always_comb begin
        int unsigned cand;
        cand    = 0;
        win_idx = '0;
        for (int k = PORTS - 1; k >= 0; k--) begin
            cand = int'(ptr_idx) + k;
            if (cand >= PORTS) begin
                cand = cand - PORTS;
            end
            if (bus.req[PW'(cand)]) begin
                win_idx = PW'(cand);
            end
        end
    end

    // Weight of the winner, zero treated as one packet per turn
    always_comb begin
        win_weight = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (win_idx == PW'(i)) begin
                win_weight = bus.weight[i*WWIDTH +: WWIDTH];
            end
        end
        if (win_weight == '0) begin
            win_weight = WWIDTH'(1);
        end
    end

    assign req_g   = bus.req[grant_port_q];
    assign last_g  = bus.last[grant_port_q];
    assign cnt_inc = {1'b0, pkt_cnt_q} + (WWIDTH+1)'(1);

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        grant_port_d = grant_port_q;
        grant_dv_d   = grant_dv_q;
        wt_lat_d     = wt_lat_q;
        pkt_cnt_d    = pkt_cnt_q;
        at_bound_d   = at_bound_q;
        prio_ptr_d   = prio_ptr_q;

        unique case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d      = GRANT;
                    grant_d      = PORTS'(1) << win_idx;
                    grant_port_d = win_idx;
                    grant_dv_d   = 1'b1;
                    wt_lat_d     = win_weight;
                    pkt_cnt_d    = '0;
                    at_bound_d   = 1'b1;
                end
            end
            GRANT: begin
                logic release_now;
                release_now = 1'b0;
                if (req_g && bus.ready) begin
                    at_bound_d = 1'b0;
                    if (last_g) begin
                        at_bound_d = 1'b1;
                        if (cnt_inc < {1'b0, wt_lat_q}) begin
                            pkt_cnt_d = pkt_cnt_q + WWIDTH'(1);
                        end else begin
                            release_now = 1'b1;
                        end
                    end
                end else if (at_bound_q && !req_g) begin
                    release_now = 1'b1;
                end
                if (release_now) begin
                    state_d    = IDLE;
                    grant_d    = '0;
                    grant_dv_d = 1'b0;
                    prio_ptr_d = {grant_q[PORTS-2:0], grant_q[PORTS-1]};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            grant_port_q <= '0;
            grant_dv_q   <= 1'b0;
            wt_lat_q     <= WWIDTH'(1);
            pkt_cnt_q    <= '0;
            at_bound_q   <= 1'b1;
            prio_ptr_q   <= PORTS'(1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            grant_port_q <= grant_port_d;
            grant_dv_q   <= grant_dv_d;
            wt_lat_q     <= wt_lat_d;
            pkt_cnt_q    <= pkt_cnt_d;
            at_bound_q   <= at_bound_d;
            prio_ptr_q   <= prio_ptr_d;
        end
    end

    assign port_ready_c   = grant_q & {PORTS{bus.ready & grant_dv_q}};
    assign bus.port_ready = port_ready_c;
    assign bus.xfer       = |(port_ready_c & bus.req);
    assign bus.grant      = grant_q;
    assign bus.grant_port = grant_port_q;
    assign bus.grant_dv   = grant_dv_q;
endmodule
